ping_sequencer: RTL and testbench

Transmit-side timing master for one sonar ping.
- On a start request it gates the transmit beamformer for a fixed carrier burst, then blanks the receiver during transducer ring-down, then opens a listen window.
- Emits the one-cycle trigger that starts time_of_flight, and reports the first qualified echo or a timeout.
- Sits between control buttons/logic and transmit_beamformer, alongside time_of_flight.

---
 rtl/ping_sequencer_if.sv | 28 ++
 rtl/ping_sequencer.sv | 150 +++++++++++++++
 tb/tb_ping_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ping_sequencer_if.sv
// Control and status bundle between ping control logic and ping_sequencer.
interface ping_sequencer_if #(
  parameter int unsigned CNT_W = 32
);
  logic             start_in;
  logic             abort_in;
  logic             echo_detected_in;
  logic             tx_enable_out;
  logic             tof_trigger_out;
  logic             blank_out;
  logic             listening_out;
  logic             echo_valid_out;
  logic [CNT_W-1:0] echo_time_out;
  logic             timeout_out;
  logic             busy_out;

  modport master (
    output start_in, abort_in, echo_detected_in,
    input  tx_enable_out, tof_trigger_out, blank_out, listening_out,
           echo_valid_out, echo_time_out, timeout_out, busy_out
  );

  modport slave (
    input  start_in, abort_in, echo_detected_in,
    output tx_enable_out, tof_trigger_out, blank_out, listening_out,
           echo_valid_out, echo_time_out, timeout_out, busy_out
  );
endinterface

// File: rtl/ping_sequencer.sv
// Sonar ping timing master: burst, ring-down blanking, listen window, holdoff.
// Optional echo qualification filter enabled by defining PING_ECHO_QUAL_EN.
module ping_sequencer #(
  parameter int unsigned CARRIER_DIV    = 2500,
  parameter int unsigned BURST_PERIODS  = 8,
  parameter int unsigned BLANK_CYCLES   = 100000,
  parameter int unsigned LISTEN_CYCLES  = 2000000,
  parameter int unsigned HOLDOFF_CYCLES = 500000,
  parameter int unsigned CNT_W          = 32
`ifdef PING_ECHO_QUAL_EN
  ,
  parameter int unsigned ECHO_QUAL_CYCLES = 4
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  ping_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] BURST_LAST  = CNT_W'(BURST_PERIODS * CARRIER_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] LISTEN_LAST = CNT_W'(LISTEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_BURST, S_BLANK, S_LISTEN, S_HOLDOFF
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] phase_q;
  logic [CNT_W-1:0] elapsed_q;
  logic [CNT_W-1:0] echo_time_q;
  logic             echo_qual_c;
  logic [CNT_W-1:0] echo_stamp_c;
  logic             echo_hit_c, timeout_hit_c, launch_c;
  logic             tx_d, trig_d, blank_d, listen_d, valid_d, tout_d, busy_d;
  logic             tx_q, trig_q, blank_q, listen_q, valid_q, tout_q, busy_q;

`ifdef PING_ECHO_QUAL_EN
  // Run length of consecutive high LISTEN cycles and the elapsed count where the run began.
  logic [CNT_W-1:0] run_q, run_start_q;

  assign echo_qual_c  = (state_q == S_LISTEN) && bus.echo_detected_in &&
                        (run_q == CNT_W'(ECHO_QUAL_CYCLES - 1));
  assign echo_stamp_c = (run_q == '0) ? elapsed_q : run_start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= '0;
      run_start_q <= '0;
    end else begin
      if ((state_q == S_LISTEN) && (state_d == S_LISTEN) && bus.echo_detected_in)
        run_q <= run_q + 1'b1;
      else
        run_q <= '0;
      if ((state_q == S_LISTEN) && bus.echo_detected_in && (run_q == '0))
        run_start_q <= elapsed_q;
    end
  end
`else
  assign echo_qual_c  = (state_q == S_LISTEN) && bus.echo_detected_in;
  assign echo_stamp_c = elapsed_q;
`endif

  // State register plus counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      elapsed_q   <= '0;
      echo_time_q <= '0;
      tx_q        <= 1'b0;
      trig_q      <= 1'b0;
      blank_q     <= 1'b0;
      listen_q    <= 1'b0;
      valid_q     <= 1'b0;
      tout_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= (state_d != state_q) ? '0 : phase_q + 1'b1;
      if (launch_c)
        elapsed_q <= '0;
      else if (elapsed_q != '1)
        elapsed_q <= elapsed_q + 1'b1;
      if (launch_c)
        echo_time_q <= '0;
      else if (echo_hit_c)
        echo_time_q <= echo_stamp_c;
      tx_q     <= tx_d;
      trig_q   <= trig_d;
      blank_q  <= blank_d;
      listen_q <= listen_d;
      valid_q  <= valid_d;
      tout_q   <= tout_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state logic; an echo on the final LISTEN cycle beats the timeout.
  always_comb begin
    state_d       = state_q;
    echo_hit_c    = 1'b0;
    timeout_hit_c = 1'b0;
    if (bus.abort_in) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (bus.start_in) state_d = S_BURST;
        S_BURST:   if (phase_q == BURST_LAST)
                     state_d = (BLANK_CYCLES == 0) ? S_LISTEN : S_BLANK;
        S_BLANK:   if (phase_q == BLANK_LAST) state_d = S_LISTEN;
        S_LISTEN: begin
          if (echo_qual_c) begin
            echo_hit_c = 1'b1;
            state_d    = S_HOLDOFF;
          end else if (phase_q == LISTEN_LAST) begin
            timeout_hit_c = 1'b1;
            state_d       = S_HOLDOFF;
          end
        end
        S_HOLDOFF: if (phase_q == HOLD_LAST)
                     state_d = bus.start_in ? S_BURST : S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Output logic: next-cycle output values derived from the next state.
  always_comb begin
    launch_c = (state_d == S_BURST) && (state_q != S_BURST);
    tx_d     = (state_d == S_BURST);
    trig_d   = launch_c;
    blank_d  = (state_d == S_BLANK);
    listen_d = (state_d == S_LISTEN);
    valid_d  = echo_hit_c;
    tout_d   = timeout_hit_c;
    busy_d   = (state_d != S_IDLE);
  end

  assign bus.tx_enable_out   = tx_q;
  assign bus.tof_trigger_out = trig_q;
  assign bus.blank_out       = blank_q;
  assign bus.listening_out   = listen_q;
  assign bus.echo_valid_out  = valid_q;
  assign bus.echo_time_out   = echo_time_q;
  assign bus.timeout_out     = tout_q;
  assign bus.busy_out        = busy_q;

endmodule

// File: tb/tb_ping_sequencer.sv
// Self-checking bench for ping_sequencer: directed test-plan pings plus random
// stimulus compared every cycle against a timeline model of one ping.
module tb_ping_sequencer;

  localparam int B = 8;   // burst cycles (CARRIER_DIV*BURST_PERIODS)
  localparam int K = 5;   // blank cycles
  localparam int L = 20;  // listen cycles
  localparam int H = 3;   // holdoff cycles
`ifdef PING_ECHO_QUAL_EN
  localparam int Q = 4;
`else
  localparam int Q = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ping_sequencer_if #(.CNT_W(32)) bus ();

  ping_sequencer #(
    .CARRIER_DIV(4), .BURST_PERIODS(2), .BLANK_CYCLES(5),
    .LISTEN_CYCLES(20), .HOLDOFF_CYCLES(3), .CNT_W(32)
`ifdef PING_ECHO_QUAL_EN
    , .ECHO_QUAL_CYCLES(4)
`endif
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int passed = 0;
  int failed = 0;
  int cyc = 0;

  // Reference model: one ping described by its trigger cycle and end cycle.
  bit          m_active = 1'b0;
  int          m_t0 = 0;
  int          m_e = -1;
  bit          m_res_echo = 1'b0;
  int          m_qrun = 0;
  int          m_qstart = 0;
  logic [31:0] m_time = '0;

  int trig_q[$];
  int ev_n, to_n, ev_cyc, to_cyc;
  logic [31:0] ev_time;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic launch();
    m_active = 1'b1;
    m_t0     = cyc + 1;
    m_e      = -1;
    m_qrun   = 0;
    m_time   = '0;
  endtask

  // Advance the model by the inputs seen in the current cycle.
  task automatic model_update(input bit st, input bit ab, input bit ec);
    int r;
    r = cyc - m_t0;
    if (ab) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (st) launch();
    end else if (m_e < 0) begin
      if (r >= B + K) begin
        if (ec) begin
          if (m_qrun == 0) m_qstart = r;
          m_qrun++;
        end else begin
          m_qrun = 0;
        end
        if (m_qrun >= Q) begin
          m_e = cyc + 1; m_res_echo = 1'b1; m_time = 32'(m_qstart);
        end else if (r == B + K + L - 1) begin
          m_e = cyc + 1; m_res_echo = 1'b0;
        end
      end
    end else if (cyc == m_e + H - 1) begin
      if (st) launch();
      else m_active = 1'b0;
    end
  endtask

  task automatic compare_all();
    int r;
    bit run;
    r   = cyc - m_t0;
    run = m_active && (m_e < 0);
    chk1("tx_enable",   bus.tx_enable_out,   run && r < B);
    chk1("tof_trigger", bus.tof_trigger_out, run && r == 0);
    chk1("blank",       bus.blank_out,       run && r >= B && r < B + K);
    chk1("listening",   bus.listening_out,   run && r >= B + K);
    chk1("echo_valid",  bus.echo_valid_out,  m_active && cyc == m_e && m_res_echo);
    chk1("timeout",     bus.timeout_out,     m_active && cyc == m_e && !m_res_echo);
    chk1("busy",        bus.busy_out,        m_active);
    chkw("echo_time",   bus.echo_time_out,   m_time);
  endtask

  task automatic clear_ev();
    trig_q.delete();
    ev_n = 0; to_n = 0; ev_cyc = -1; to_cyc = -1; ev_time = '0;
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, update model.
  task automatic step(input bit st, input bit ab, input bit ec);
    bus.start_in = st; bus.abort_in = ab; bus.echo_detected_in = ec;
    @(negedge clk);
    compare_all();
    if (bus.tof_trigger_out) trig_q.push_back(cyc);
    if (bus.echo_valid_out) begin ev_n++; ev_cyc = cyc; ev_time = bus.echo_time_out; end
    if (bus.timeout_out) begin to_n++; to_cyc = cyc; end
    model_update(st, ab, ec);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && m_active; i++) step(1'b0, 1'b0, 1'b0);
    chk1("drain_idle", m_active, 1'b0);
  endtask

  initial begin
    int s, t;
    bit ec;
    bus.start_in = 1'b0; bus.abort_in = 1'b0; bus.echo_detected_in = 1'b0;
    clear_ev();

    // Outputs under reset.
    repeat (2) @(negedge clk);
    chk1("rst_tx", bus.tx_enable_out, 1'b0);
    chk1("rst_busy", bus.busy_out, 1'b0);
    chk1("rst_trig", bus.tof_trigger_out, 1'b0);
    chkw("rst_time", bus.echo_time_out, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;

    // Start at cycle 10, echo at cycle 24 only.
    for (int i = 0; i <= 40; i++) step(i == 10, 1'b0, cyc == 24);
    chkw("a_trig_cyc", 32'(trig_q.size() > 0 ? trig_q[0] : -1), 32'd11);
`ifndef PING_ECHO_QUAL_EN
    chkw("a_ev_cyc", 32'(ev_cyc), 32'd25);
    chkw("a_ev_time", ev_time, 32'd13);
`else
    chkw("a_qual_reject", 32'(ev_n), 32'd0);
`endif

    // No echo: single timeout 20 cycles after LISTEN entry.
    clear_ev();
    step(1'b1, 1'b0, 1'b0);
    repeat (45) step(1'b0, 1'b0, 1'b0);
    chkw("b_to_n", 32'(to_n), 32'd1);
    chkw("b_ev_n", 32'(ev_n), 32'd0);
    chkw("b_to_delay", 32'(to_cyc - (trig_q.size() > 0 ? trig_q[0] : 0)), 32'(B + K + L));

    // Echo high through BURST and BLANK only.
    clear_ev();
    step(1'b1, 1'b0, 1'b1);
    repeat (B + K) step(1'b0, 1'b0, 1'b1);
    repeat (40) step(1'b0, 1'b0, 1'b0);
    chkw("c_ev_n", 32'(ev_n), 32'd0);
    chkw("c_to_n", 32'(to_n), 32'd1);

    // Abort on the third BURST cycle, then start+abort together in IDLE.
    clear_ev();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (40) step(1'b0, 1'b0, 1'b1);
    chkw("d_trig_n", 32'(trig_q.size()), 32'd1);
    chkw("d_ev_n", 32'(ev_n), 32'd0);
    chkw("d_to_n", 32'(to_n), 32'd0);
    chkw("d_time", bus.echo_time_out, 32'd0);

    // start_in held high: back-to-back pings.
    clear_ev();
    repeat (110) step(1'b1, 1'b0, 1'b0);
    chk1("e_count", trig_q.size() >= 3, 1'b1);
    for (int i = 1; i < trig_q.size(); i++)
      chkw("e_spacing", 32'(trig_q[i] - trig_q[i-1]), 32'(B + K + H + L));
    drain();

    // Echo run of 3 at elapsed 13..15, then a run of 4 at 15..18.
    clear_ev();
    step(1'b1, 1'b0, 1'b0);
    t = cyc;
    for (int i = 0; i < 45; i++) step(1'b0, 1'b0, (cyc - t) >= 13 && (cyc - t) <= 15);
    drain();
`ifdef PING_ECHO_QUAL_EN
    chkw("f_run3_ev", 32'(ev_n), 32'd0);
    chkw("f_run3_to", 32'(to_n), 32'd1);
`endif
    clear_ev();
    step(1'b1, 1'b0, 1'b0);
    t = cyc;
    for (int i = 0; i < 45; i++) step(1'b0, 1'b0, (cyc - t) >= 15 && (cyc - t) <= 18);
    chkw("f_ev_n", 32'(ev_n), 32'd1);
    chkw("f_ev_time", ev_time, 32'd15);
    drain();

    // Asynchronous reset mid-burst drops tx_enable without a clock edge.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk1("g_tx_pre", bus.tx_enable_out, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("g_tx_rst", bus.tx_enable_out, 1'b0);
    chk1("g_busy_rst", bus.busy_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    m_active = 1'b0;
    m_time = '0;
    @(posedge clk);
    #1;
    cyc++;

    // Random start/abort with bursty echoes against the model.
    ec = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) ec = ~ec;
      step($urandom_range(0, 7) == 0, $urandom_range(0, 79) == 0, ec);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
